// File: rtl/mrd_sched_pkg.sv
// Shared types and constants for the mixed-radix DFT stage scheduler:
// FSM state encoding, radix codes, default sizing and the stage command entry.
package mrd_sched_pkg;

    localparam int MAX_STAGES_DEF = 12;
    localparam int PTS_W_DEF      = 12;

    // Radix codes are the radix values themselves so they can feed the
    // span multiplier and the stage command without translation.
    typedef logic [2:0] radix_t;

    localparam radix_t RDX_NONE = 3'd0;
    localparam radix_t RDX2     = 3'd2;
    localparam radix_t RDX3     = 3'd3;
    localparam radix_t RDX4     = 3'd4;
    localparam radix_t RDX5     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FACTOR,
        ST_LOAD,
        ST_STG_ISSUE,
        ST_STG_WAIT,
        ST_OUT_ISSUE,
        ST_OUT_WAIT
    } sched_state_t;

    // One butterfly stage command as presented to memory / radix core.
    typedef struct packed {
        radix_t     radix;
        logic [3:0] idx;
        logic       last;
    } stage_entry_t;

endpackage

// File: rtl/mrd_factorizer.sv
// Iterative point-count factorizer: peels one radix per cycle off the residue
// and appends it to a stage list that the scheduler reads back by index.
// Build option: MRD_SCHED_RDX4_EN enables radix 4 (tried before radix 2);
// without it the priority is 2, 3, 5 and radix 4 is never produced.
module mrd_factorizer
    import mrd_sched_pkg::*;
#(
    parameter int PTS_W      = PTS_W_DEF,
    parameter int MAX_STAGES = MAX_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [PTS_W-1:0] i_pts,
    input  logic [3:0]       i_rd_idx,
    output logic             o_done,
    output logic             o_err,
    output logic [3:0]       o_count,
    output radix_t           o_rd_radix
);

    localparam logic [3:0]       MAX_CNT = 4'(MAX_STAGES);
    localparam logic [PTS_W-1:0] ONE     = PTS_W'(1);
    localparam logic [PTS_W-1:0] TWO     = PTS_W'(2);

    logic [PTS_W-1:0] r_n;
    logic [3:0]       r_count;
    logic             r_active;
    logic             r_bad;
    radix_t           r_list [MAX_STAGES];

    radix_t           w_radix;
    logic [PTS_W-1:0] w_quot;

    // Pick the next radix; later assignments win, giving priority 4, 2, 3, 5.
    always_comb begin
        w_radix = RDX_NONE;
        if ((r_n % PTS_W'(5)) == '0) w_radix = RDX5;
        if ((r_n % PTS_W'(3)) == '0) w_radix = RDX3;
        if (r_n[0] == 1'b0)          w_radix = RDX2;
`ifdef MRD_SCHED_RDX4_EN
        if (r_n[1:0] == 2'b00)       w_radix = RDX4;
`endif
    end

    // Divide the residue by the chosen radix (constant divisors only).
    always_comb begin
        case (w_radix)
            RDX2:    w_quot = r_n >> 1;
            RDX3:    w_quot = r_n / PTS_W'(3);
            RDX4:    w_quot = r_n >> 2;
            RDX5:    w_quot = r_n / PTS_W'(5);
            default: w_quot = r_n;
        endcase
    end

    // A point count below 2 is rejected outright; otherwise the run ends when
    // the residue reaches 1, or fails on an unusable prime or a full list.
    assign o_done = r_active && !r_bad && (r_n == ONE);
    assign o_err  = r_active && (r_bad ||
                    ((r_n != ONE) && ((r_count == MAX_CNT) || (w_radix == RDX_NONE))));

    // Residue, stage count and stage list update: one factor per cycle while active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n      <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
            r_bad    <= 1'b0;
            for (int i = 0; i < MAX_STAGES; i++) begin
                r_list[i] <= RDX_NONE;
            end
        end else if (i_start) begin
            r_n      <= i_pts;
            r_count  <= '0;
            r_active <= 1'b1;
            r_bad    <= (i_pts < TWO);
        end else if (r_active) begin
            if (o_done || o_err) begin
                r_active <= 1'b0;
            end else begin
                r_list[r_count] <= w_radix;
                r_n             <= w_quot;
                r_count         <= r_count + 4'd1;
            end
        end
    end

    assign o_count    = r_count;
    assign o_rd_radix = (i_rd_idx < MAX_CNT) ? r_list[i_rd_idx] : RDX_NONE;

endmodule

// File: rtl/mrd_stage_sched.sv
// Stage scheduler for the mixed-radix DFT engine: accepts a frame at SOP,
// factors its point count, then walks memory and radix core through load,
// every butterfly stage and unload using valid/ready commands and done pulses.
// Build option: MRD_SCHED_RDX4_EN (passed through to mrd_factorizer).
module mrd_stage_sched
    import mrd_sched_pkg::*;
#(
    parameter int MAX_STAGES = MAX_STAGES_DEF,
    parameter int PTS_W      = PTS_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sop_in,
    input  logic [PTS_W-1:0] dftpts_in,
    input  logic             inverse_in,
    input  logic             in_done,
    output logic             stg_valid,
    input  logic             stg_ready,
    output logic [2:0]       stg_radix,
    output logic [3:0]       stg_idx,
    output logic [PTS_W-1:0] stg_span,
    output logic             stg_last,
    input  logic             stg_done,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             out_done,
    output logic [PTS_W-1:0] cur_pts,
    output logic             cur_inverse,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_err,
    output logic             sop_drop
);

    localparam logic [PTS_W-1:0] ONE = PTS_W'(1);

    sched_state_t     r_state;
    logic [PTS_W-1:0] r_pts;
    logic             r_inv;
    logic             r_in_seen;
    logic [3:0]       r_idx;
    logic [PTS_W-1:0] r_span;
    logic             r_frame_done;
    logic             r_cfg_err;
    logic             r_sop_drop;

    sched_state_t     w_next;
    logic             w_sop_accept;
    logic             w_stg_complete;
    logic             w_out_complete;
    logic             w_fact_err;
    logic             w_done;
    logic             w_err;
    logic [3:0]       w_count;
    radix_t           w_rd_radix;
    logic [3:0]       w_idx_inc;
    stage_entry_t     w_cmd;

    mrd_factorizer #(
        .PTS_W      (PTS_W),
        .MAX_STAGES (MAX_STAGES)
    ) u_factorizer (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_sop_accept),
        .i_pts      (dftpts_in),
        .i_rd_idx   (r_idx),
        .o_done     (w_done),
        .o_err      (w_err),
        .o_count    (w_count),
        .o_rd_radix (w_rd_radix)
    );

    assign w_idx_inc = r_idx + 4'd1;

    // Frame sequencing: next state plus the single-cycle events it produces.
    always_comb begin
        w_next         = r_state;
        w_sop_accept   = 1'b0;
        w_stg_complete = 1'b0;
        w_out_complete = 1'b0;
        w_fact_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sop_in) begin
                    w_sop_accept = 1'b1;
                    w_next       = ST_FACTOR;
                end
            end
            ST_FACTOR: begin
                if (w_err) begin
                    w_fact_err = 1'b1;
                    w_next     = ST_IDLE;
                end else if (w_done) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_done || r_in_seen) w_next = ST_STG_ISSUE;
            end
            ST_STG_ISSUE: begin
                if (stg_ready) w_next = ST_STG_WAIT;
            end
            ST_STG_WAIT: begin
                if (stg_done) begin
                    w_stg_complete = 1'b1;
                    w_next         = (w_idx_inc == w_count) ? ST_OUT_ISSUE : ST_STG_ISSUE;
                end
            end
            ST_OUT_ISSUE: begin
                if (out_ready) w_next = ST_OUT_WAIT;
            end
            ST_OUT_WAIT: begin
                if (out_done) begin
                    w_out_complete = 1'b1;
                    w_next         = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame context, early in_done latch, stage index/span accumulator and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pts        <= '0;
            r_inv        <= 1'b0;
            r_in_seen    <= 1'b0;
            r_idx        <= '0;
            r_span       <= '0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_sop_drop   <= 1'b0;
        end else begin
            r_frame_done <= w_out_complete;
            r_cfg_err    <= w_fact_err;
            r_sop_drop   <= sop_in && (r_state != ST_IDLE);
            if (w_sop_accept) begin
                r_pts     <= dftpts_in;
                r_inv     <= inverse_in;
                r_in_seen <= 1'b0;
                r_idx     <= '0;
                r_span    <= ONE;
            end else begin
                if ((r_state == ST_FACTOR) && in_done) r_in_seen <= 1'b1;
                if (w_stg_complete) begin
                    r_span <= r_span * PTS_W'(w_rd_radix);
                    r_idx  <= w_idx_inc;
                end
            end
        end
    end

    // Stage command fields are forced to zero whenever no command is offered.
    always_comb begin
        w_cmd = '0;
        if (r_state == ST_STG_ISSUE) begin
            w_cmd.radix = w_rd_radix;
            w_cmd.idx   = r_idx;
            w_cmd.last  = (w_idx_inc == w_count);
        end
    end

    assign stg_valid   = (r_state == ST_STG_ISSUE);
    assign stg_radix   = w_cmd.radix;
    assign stg_idx     = w_cmd.idx;
    assign stg_last    = w_cmd.last;
    assign stg_span    = stg_valid ? r_span : '0;
    assign out_valid   = (r_state == ST_OUT_ISSUE);
    assign busy        = (r_state != ST_IDLE);
    assign cur_pts     = r_pts;
    assign cur_inverse = r_inv;
    assign frame_done  = r_frame_done;
    assign cfg_err     = r_cfg_err;
    assign sop_drop    = r_sop_drop;

endmodule

// File: tb/tb_mrd_stage_sched.sv
// Directed bench for mrd_stage_sched: reset state, full frame sequencing,
// unsupported point counts, command stalls with stray pulses, mid-frame reset.
// Expected stage lists follow MRD_SCHED_RDX4_EN when it is defined.
module tb_mrd_stage_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        sop_in;
    logic [11:0] dftpts_in;
    logic        inverse_in;
    logic        in_done;
    logic        stg_valid;
    logic        stg_ready;
    logic [2:0]  stg_radix;
    logic [3:0]  stg_idx;
    logic [11:0] stg_span;
    logic        stg_last;
    logic        stg_done;
    logic        out_valid;
    logic        out_ready;
    logic        out_done;
    logic [11:0] cur_pts;
    logic        cur_inverse;
    logic        busy;
    logic        frame_done;
    logic        cfg_err;
    logic        sop_drop;

    int checks = 0;
    int errors = 0;

    mrd_stage_sched dut (
        .clk         (clk),
        .rst         (rst),
        .sop_in      (sop_in),
        .dftpts_in   (dftpts_in),
        .inverse_in  (inverse_in),
        .in_done     (in_done),
        .stg_valid   (stg_valid),
        .stg_ready   (stg_ready),
        .stg_radix   (stg_radix),
        .stg_idx     (stg_idx),
        .stg_span    (stg_span),
        .stg_last    (stg_last),
        .stg_done    (stg_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_done    (out_done),
        .cur_pts     (cur_pts),
        .cur_inverse (cur_inverse),
        .busy        (busy),
        .frame_done  (frame_done),
        .cfg_err     (cfg_err),
        .sop_drop    (sop_drop)
    );

    always #5 clk = ~clk;

    // Present one SOP cycle; returns just after the accepting edge.
    task automatic startFrame(input logic [11:0] pts, input logic inv);
        @(posedge clk); #1;
        sop_in     = 1'b1;
        dftpts_in  = pts;
        inverse_in = inv;
        @(posedge clk); #1;
        sop_in = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sop_in = 0; dftpts_in = 0; inverse_in = 0; in_done = 0;
        stg_ready = 0; stg_done = 0; out_ready = 0; out_done = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stg_valid, stg_radix, stg_idx, stg_span, stg_last, out_valid, cur_pts,
             cur_inverse, busy, frame_done, cfg_err, sop_drop} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%0b stg_valid=%0b cur_pts=%0d, expected all zero",
                     busy, stg_valid, cur_pts);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stg_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got busy=%0b stg_valid=%0b, expected 0 0", busy, stg_valid);
        end
    endtask

    task automatic test_frame_1200;
        int expR[7];
        int expS[7];
        int nStg;
        int cyc;
        int expCyc;
`ifdef MRD_SCHED_RDX4_EN
        nStg = 5;
        expR = '{4, 4, 3, 5, 5, 0, 0};
        expS = '{1, 4, 16, 48, 240, 0, 0};
`else
        nStg = 7;
        expR = '{2, 2, 2, 2, 3, 5, 5};
        expS = '{1, 2, 4, 8, 16, 48, 240};
`endif
        startFrame(12'd1200, 1'b1);
        // in_done arrives while factoring is still under way
        in_done = 1'b1;
        @(posedge clk); #1;
        in_done = 1'b0;
        for (int i = 0; i < nStg; i++) begin
            cyc = 0;
            @(negedge clk);
            while (stg_valid !== 1'b1 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            if (stg_valid !== 1'b1) begin
                checks++; errors++;
                $display("[TB] FAIL f1200_valid_timeout stage %0d: got stg_valid=%0b, expected 1", i, stg_valid);
                break;
            end
            expCyc = (i == 0) ? nStg + 1 : 0;
            checks++;
            if (cyc !== expCyc) begin
                errors++;
                $display("[TB] FAIL f1200_latency stage %0d: got %0d cycles, expected %0d", i, cyc, expCyc);
            end
            checks++;
            if (stg_radix !== 3'(expR[i]) || stg_idx !== 4'(i) || stg_span !== 12'(expS[i]) ||
                stg_last !== (i == nStg - 1)) begin
                errors++;
                $display("[TB] FAIL f1200_cmd stage %0d: got radix=%0d idx=%0d span=%0d last=%0b, expected radix=%0d idx=%0d span=%0d last=%0b",
                         i, stg_radix, stg_idx, stg_span, stg_last, expR[i], i, expS[i], (i == nStg - 1));
            end
            stg_ready = 1'b1;
            @(posedge clk); #1;
            stg_ready = 1'b0;
            if (i == 0) begin
                sop_in = 1'b1; dftpts_in = 12'd99; inverse_in = 1'b0;
                @(posedge clk); #1;
                sop_in = 1'b0;
                @(negedge clk);
                checks++;
                if (sop_drop !== 1'b1 || stg_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL f1200_sop_drop: got sop_drop=%0b stg_valid=%0b busy=%0b, expected 1 0 1",
                             sop_drop, stg_valid, busy);
                end
            end
            stg_done = 1'b1;
            @(posedge clk); #1;
            stg_done = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || stg_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL f1200_out_issue: got out_valid=%0b stg_valid=%0b, expected 1 0", out_valid, stg_valid);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL f1200_out_wait: got out_valid=%0b busy=%0b frame_done=%0b, expected 0 1 0",
                     out_valid, busy, frame_done);
        end
        out_done = 1'b1;
        @(posedge clk); #1;
        out_done = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || cur_pts !== 12'd1200 || cur_inverse !== 1'b1) begin
            errors++;
            $display("[TB] FAIL f1200_done: got frame_done=%0b busy=%0b cur_pts=%0d cur_inverse=%0b, expected 1 0 1200 1",
                     frame_done, busy, cur_pts, cur_inverse);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL f1200_done_width: got frame_done=%0b, expected 0", frame_done);
        end
    endtask

    task automatic test_cfg_err;
        // 4096 does not fit the 12-bit field and arrives as 0
        logic [11:0] ptsList [4];
        int          latList [4];
        int          cyc;
        logic        sawValid;
        ptsList = '{12'd7, 12'd1, 12'd0, 12'd4095};
        latList = '{1, 1, 1, 4};
        for (int k = 0; k < 4; k++) begin
            startFrame(ptsList[k], 1'b0);
            cyc = 0;
            sawValid = 1'b0;
            @(negedge clk);
            while (cfg_err !== 1'b1 && cyc < 10) begin
                if (stg_valid === 1'b1) sawValid = 1'b1;
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0 || sawValid !== 1'b0 || stg_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cfg_err pts=%0d: got cfg_err=%0b busy=%0b sawValid=%0b, expected 1 0 0",
                         ptsList[k], cfg_err, busy, sawValid);
            end
            checks++;
            if (cyc !== latList[k]) begin
                errors++;
                $display("[TB] FAIL cfg_err_latency pts=%0d: got %0d, expected %0d", ptsList[k], cyc, latList[k]);
            end
            @(negedge clk);
            checks++;
            if (cfg_err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cfg_err_width pts=%0d: got cfg_err=%0b busy=%0b, expected 0 0",
                         ptsList[k], cfg_err, busy);
            end
        end
    endtask

    task automatic test_stall_36;
        int   expR[4];
        int   expS[4];
        int   nStg;
        logic sawValid;
        logic stable;
`ifdef MRD_SCHED_RDX4_EN
        nStg = 3;
        expR = '{4, 3, 3, 0};
        expS = '{1, 4, 12, 0};
`else
        nStg = 4;
        expR = '{2, 2, 3, 3};
        expS = '{1, 2, 4, 12};
`endif
        startFrame(12'd36, 1'b0);
        sawValid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (stg_valid === 1'b1) sawValid = 1'b1;
        end
        checks++;
        if (sawValid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL s36_load_wait: got sawValid=%0b busy=%0b, expected 0 1", sawValid, busy);
        end
        in_done = 1'b1;
        @(posedge clk); #1;
        in_done = 1'b0;
        @(negedge clk);
        checks++;
        if (stg_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL s36_load_exit: got stg_valid=%0b, expected 1", stg_valid);
        end
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) stg_done = 1'b1;
            @(posedge clk); #1;
            stg_done = 1'b0;
            @(negedge clk);
            if (stg_valid !== 1'b1 || stg_radix !== 3'(expR[0]) || stg_idx !== 4'd0 ||
                stg_span !== 12'd1 || stg_last !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL s36_stall: got valid=%0b radix=%0d idx=%0d span=%0d, expected 1 %0d 0 1",
                     stg_valid, stg_radix, stg_idx, stg_span, expR[0]);
        end
        for (int i = 0; i < nStg; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (stg_valid !== 1'b1 || stg_radix !== 3'(expR[i]) || stg_idx !== 4'(i) ||
                stg_span !== 12'(expS[i]) || stg_last !== (i == nStg - 1)) begin
                errors++;
                $display("[TB] FAIL s36_cmd stage %0d: got valid=%0b radix=%0d idx=%0d span=%0d last=%0b, expected 1 %0d %0d %0d %0b",
                         i, stg_valid, stg_radix, stg_idx, stg_span, stg_last, expR[i], i, expS[i], (i == nStg - 1));
            end
            stg_ready = 1'b1;
            @(posedge clk); #1;
            stg_ready = 1'b0;
            stg_done = 1'b1;
            @(posedge clk); #1;
            stg_done = 1'b0;
        end
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL s36_out_hold: got out_valid=%0b, expected held 1", out_valid);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        out_done = 1'b1; sop_in = 1'b1; dftpts_in = 12'd500; inverse_in = 1'b1;
        @(posedge clk); #1;
        out_done = 1'b0; sop_in = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || sop_drop !== 1'b1 || busy !== 1'b0 ||
            cur_pts !== 12'd36 || cur_inverse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL s36_done_vs_sop: got frame_done=%0b sop_drop=%0b busy=%0b cur_pts=%0d cur_inv=%0b, expected 1 1 0 36 0",
                     frame_done, sop_drop, busy, cur_pts, cur_inverse);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || sop_drop !== 1'b0) begin
            errors++;
            $display("[TB] FAIL s36_idle_after: got busy=%0b frame_done=%0b sop_drop=%0b, expected 0 0 0",
                     busy, frame_done, sop_drop);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        startFrame(12'd1200, 1'b1);
        in_done = 1'b1;
        @(posedge clk); #1;
        in_done = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (stg_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (stg_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rmid_valid_timeout: got stg_valid=%0b, expected 1", stg_valid);
        end
        stg_ready = 1'b1;
        @(posedge clk); #1;
        stg_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({stg_valid, stg_radix, stg_idx, stg_span, stg_last, out_valid, cur_pts,
             cur_inverse, busy, frame_done, cfg_err, sop_drop} !== '0) begin
            errors++;
            $display("[TB] FAIL rmid_outputs: got busy=%0b cur_pts=%0d cur_inv=%0b, expected all zero",
                     busy, cur_pts, cur_inverse);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        stg_done = 1'b1;
        @(posedge clk); #1;
        stg_done = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || stg_valid !== 1'b0 || frame_done !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmid_idle: got busy=%0b stg_valid=%0b frame_done=%0b cfg_err=%0b, expected 0 0 0 0",
                     busy, stg_valid, frame_done, cfg_err);
        end
    endtask

    initial begin
        test_reset();
        test_frame_1200();
        test_cfg_err();
        test_stall_36();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
